// File: rtl/traffic_scheduler.sv
// Four-lane phase sequencer: green -> yellow -> all-red per lane, with empty lanes skipped and emergency preemption.
// Latency: every output is registered and reflects the sec_tick that decided it on the same clk edge.
// Backpressure: none; the sequencer only advances on sec_tick and holds all state while sec_tick is low.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   sec_tick           one-cycle pulse per second; the only event that advances state
//   car_waiting[3:0]   per-lane vehicle presence, sampled at ticks
//   emerg_req[3:0]     per-lane emergency request level, sampled at ticks
//   active_lane[1:0]   lane owning (or last owning) green
//   phase[1:0]         0 ALLRED, 1 GREEN, 2 YELLOW, 3 EMERG
//   lamp_g/y/r[3:0]    per-lane lamp drives
//   emerg_active       high while phase is EMERG
module traffic_scheduler #(
    parameter int GREEN_T   = 30,
    parameter int YELLOW_T  = 3,
    parameter int CLEAR_T   = 2,
    parameter int MIN_GREEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [3:0] car_waiting,
    input  logic [3:0] emerg_req,
    output logic [1:0] active_lane,
    output logic [1:0] phase,
    output logic [3:0] lamp_g,
    output logic [3:0] lamp_y,
    output logic [3:0] lamp_r,
    output logic       emerg_active
);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_EMERG  = 2'd3
    } phase_e;

    localparam logic [4:0] GREEN_LAST  = 5'(GREEN_T - 1);
    localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_T - 1);
    localparam logic [4:0] CLEAR_LAST  = 5'(CLEAR_T - 1);
    localparam logic [4:0] MIN_LAST    = 5'(MIN_GREEN - 1);

    phase_e     phase_q, phase_d;
    logic [1:0] lane_q, lane_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] lamp_g_q, lamp_g_d;
    logic [3:0] lamp_y_q, lamp_y_d;
    logic [3:0] lamp_r_q, lamp_r_d;
    logic       emerg_q, emerg_d;
    logic       own_emerg;
    logic       other_emerg;

    // Round-robin search starting at cur+1 and wrapping to cur itself;
    // with no cars waiting the rotation still advances by one lane.
    function automatic logic [1:0] next_car_lane(input logic [1:0] cur, input logic [3:0] cars);
        logic [1:0] sel;
        logic [1:0] cand;
        sel = cur + 2'd1;
        // Walk the search order backwards so the earliest hit is written last.
        for (int k = 4; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (cars[cand]) sel = cand;
        end
        return sel;
    endfunction

    function automatic logic [1:0] lowest_req(input logic [3:0] req);
        logic [1:0] sel;
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) sel = 2'(k);
        end
        return sel;
    endfunction

    assign own_emerg   = emerg_req[lane_q];
    assign other_emerg = (emerg_req & ~(4'b0001 << lane_q)) != 4'b0000;

    always_comb begin
        phase_d = phase_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        if (sec_tick) begin
            // Saturate so a very long EMERG hold cannot wrap the counter.
            cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
            case (phase_q)
                PH_ALLRED: begin
                    if (cnt_q == CLEAR_LAST) begin
                        cnt_d = 5'd0;
                        if (emerg_req != 4'b0000) begin
                            phase_d = PH_EMERG;
                            lane_d  = lowest_req(emerg_req);
                        end else begin
                            phase_d = PH_GREEN;
                            lane_d  = next_car_lane(lane_q, car_waiting);
                        end
                    end
                end
                PH_GREEN: begin
                    // Own-lane emergency outranks both yellow exits.
                    if (own_emerg) begin
                        phase_d = PH_EMERG;
                        cnt_d   = 5'd0;
                    end else if (cnt_q == GREEN_LAST || (other_emerg && cnt_q >= MIN_LAST)) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = 5'd0;
                    end
                end
                PH_EMERG: begin
                    if (!own_emerg) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = 5'd0;
                    end
                end
                default: begin
                    if (cnt_q == YELLOW_LAST) begin
                        phase_d = PH_ALLRED;
                        cnt_d   = 5'd0;
                    end
                end
            endcase
        end

        // Lamps are decoded from the next state so they register alongside it.
        lamp_g_d = 4'b0000;
        lamp_y_d = 4'b0000;
        case (phase_d)
            PH_GREEN, PH_EMERG: lamp_g_d = 4'b0001 << lane_d;
            PH_YELLOW:          lamp_y_d = 4'b0001 << lane_d;
            default:            ;
        endcase
        lamp_r_d = ~(lamp_g_d | lamp_y_d);
        emerg_d  = (phase_d == PH_EMERG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_ALLRED;
            lane_q   <= 2'd3;
            cnt_q    <= 5'd0;
            lamp_g_q <= 4'b0000;
            lamp_y_q <= 4'b0000;
            lamp_r_q <= 4'b1111;
            emerg_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            lamp_g_q <= lamp_g_d;
            lamp_y_q <= lamp_y_d;
            lamp_r_q <= lamp_r_d;
            emerg_q  <= emerg_d;
        end
    end

    assign phase        = phase_q;
    assign active_lane  = lane_q;
    assign lamp_g       = lamp_g_q;
    assign lamp_y       = lamp_y_q;
    assign lamp_r       = lamp_r_q;
    assign emerg_active = emerg_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler: table of {inputs, tick count, expected phase/lane} records plus hand sequences.
// Latency: ticks are one clk wide, every fourth clk; outputs sampled 1 time unit after each rising edge.
// Backpressure: none; lamp invariants are checked on every sampled cycle.
module tb_traffic_scheduler;

    localparam logic [1:0] AR = 2'd0, GR = 2'd1, YE = 2'd2, EM = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [3:0] car_waiting;
    logic [3:0] emerg_req;
    logic [1:0] active_lane;
    logic [1:0] phase;
    logic [3:0] lamp_g, lamp_y, lamp_r;
    logic       emerg_active;

    always #5 clk = ~clk;

    traffic_scheduler #(
        .GREEN_T  (30),
        .YELLOW_T (3),
        .CLEAR_T  (2),
        .MIN_GREEN(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .car_waiting (car_waiting),
        .emerg_req   (emerg_req),
        .active_lane (active_lane),
        .phase       (phase),
        .lamp_g      (lamp_g),
        .lamp_y      (lamp_y),
        .lamp_r      (lamp_r),
        .emerg_active(emerg_active)
    );

    typedef struct {
        bit         rst;
        int         n;
        logic [3:0] car;
        logic [3:0] emerg;
        logic [1:0] ph;
        logic [1:0] lane;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(bit r, int n, logic [3:0] car, logic [3:0] em,
                                logic [1:0] ph, logic [1:0] lane);
        vec_t v;
        v.rst = r; v.n = n; v.car = car; v.emerg = em; v.ph = ph; v.lane = lane;
        return v;
    endfunction

    task automatic check_inv();
        logic ok;
        ok = ($countones(~lamp_r) <= 1);
        for (int i = 0; i < 4; i++) begin
            if ($countones({lamp_g[i], lamp_y[i], lamp_r[i]}) != 1) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL lamp_invariant at %0t: g=%b y=%b r=%b", $time, lamp_g, lamp_y, lamp_r);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        check_inv();
    endtask

    task automatic check_state(string name, logic [1:0] eph, logic [1:0] elane);
        logic [3:0]  eg, ey, er;
        logic [16:0] got, exp;
        eg = 4'b0000;
        ey = 4'b0000;
        if (eph == GR || eph == EM) eg = 4'b0001 << elane;
        if (eph == YE)              ey = 4'b0001 << elane;
        er  = ~(eg | ey);
        got = {phase, active_lane, lamp_g, lamp_y, lamp_r, emerg_active};
        exp = {eph, elane, eg, ey, er, (eph == EM)};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ph=%0d lane=%0d g=%b y=%b r=%b ea=%b, want ph=%0d lane=%0d g=%b y=%b r=%b ea=%b",
                     name, phase, active_lane, lamp_g, lamp_y, lamp_r, emerg_active,
                     eph, elane, eg, ey, er, (eph == EM));
        end
    endtask

    task automatic do_tick(logic [3:0] car, logic [3:0] em);
        car_waiting = car;
        emerg_req   = em;
        sec_tick    = 1'b1;
        step_cycle();
        sec_tick    = 1'b0;
        repeat (3) step_cycle();
    endtask

    initial begin
        rst         = 1'b1;
        sec_tick    = 1'b0;
        car_waiting = 4'h0;
        emerg_req   = 4'h0;

        // Start-up and full rotation with every lane occupied.
        tbl.push_back(mk(0, 1, 4'hF, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 1, 4'hF, 4'h0, GR, 2'd0));
        for (int l = 0; l < 4; l++) begin
            tbl.push_back(mk(0, 29, 4'hF, 4'h0, GR, 2'(l)));
            tbl.push_back(mk(0, 1,  4'hF, 4'h0, YE, 2'(l)));
            tbl.push_back(mk(0, 2,  4'hF, 4'h0, YE, 2'(l)));
            tbl.push_back(mk(0, 1,  4'hF, 4'h0, AR, 2'(l)));
            tbl.push_back(mk(0, 1,  4'hF, 4'h0, AR, 2'(l)));
            tbl.push_back(mk(0, 1,  4'hF, 4'h0, GR, 2'(l + 1)));
        end
        // Skip to the only occupied lane, then advance by one with no cars.
        tbl.push_back(mk(0, 30, 4'b0100, 4'h0, YE, 2'd0));
        tbl.push_back(mk(0, 3,  4'b0100, 4'h0, AR, 2'd0));
        tbl.push_back(mk(0, 1,  4'b0100, 4'h0, AR, 2'd0));
        tbl.push_back(mk(0, 1,  4'b0100, 4'h0, GR, 2'd2));
        tbl.push_back(mk(0, 30, 4'h0, 4'h0, YE, 2'd2));
        tbl.push_back(mk(0, 3,  4'h0, 4'h0, AR, 2'd2));
        tbl.push_back(mk(0, 2,  4'h0, 4'h0, GR, 2'd3));
        tbl.push_back(mk(0, 30, 4'h0, 4'h0, YE, 2'd3));
        tbl.push_back(mk(0, 3,  4'h0, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 2,  4'h0, 4'h0, GR, 2'd0));
        // Preemption from another lane at green tick 10.
        tbl.push_back(mk(0, 10, 4'h0, 4'h0, GR, 2'd0));
        tbl.push_back(mk(0, 1,  4'h0, 4'h8, YE, 2'd0));
        tbl.push_back(mk(0, 3,  4'h0, 4'h8, AR, 2'd0));
        tbl.push_back(mk(0, 2,  4'h0, 4'h8, EM, 2'd3));
        tbl.push_back(mk(0, 5,  4'h0, 4'h8, EM, 2'd3));
        tbl.push_back(mk(0, 1,  4'h0, 4'h0, YE, 2'd3));
        tbl.push_back(mk(0, 3,  4'h0, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 2,  4'h0, 4'h0, GR, 2'd0));
        // Request held from green entry: green lasts exactly MIN_GREEN ticks.
        tbl.push_back(mk(0, 4,  4'h0, 4'h8, GR, 2'd0));
        tbl.push_back(mk(0, 1,  4'h0, 4'h8, YE, 2'd0));
        tbl.push_back(mk(0, 3,  4'h0, 4'h8, AR, 2'd0));
        tbl.push_back(mk(0, 2,  4'h0, 4'h8, EM, 2'd3));
        tbl.push_back(mk(0, 1,  4'h0, 4'h0, YE, 2'd3));
        tbl.push_back(mk(0, 3,  4'h0, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 2,  4'b0010, 4'h0, GR, 2'd1));
        // Own-lane emergency with a simultaneous request elsewhere.
        tbl.push_back(mk(0, 1,  4'h0, 4'b0110, EM, 2'd1));
        tbl.push_back(mk(0, 3,  4'h0, 4'b0110, EM, 2'd1));
        tbl.push_back(mk(0, 1,  4'h0, 4'b0100, YE, 2'd1));
        tbl.push_back(mk(0, 3,  4'h0, 4'b0100, AR, 2'd1));
        tbl.push_back(mk(0, 2,  4'h0, 4'b0100, EM, 2'd2));
        tbl.push_back(mk(0, 1,  4'h0, 4'h0, YE, 2'd2));
        tbl.push_back(mk(0, 3,  4'h0, 4'h0, AR, 2'd2));
        // Two requests decided at ALLRED exit: lowest index first.
        tbl.push_back(mk(0, 2,  4'h0, 4'b1010, EM, 2'd1));
        tbl.push_back(mk(0, 1,  4'h0, 4'b1000, YE, 2'd1));
        tbl.push_back(mk(0, 3,  4'h0, 4'b1000, AR, 2'd1));
        tbl.push_back(mk(0, 2,  4'h0, 4'b1000, EM, 2'd3));
        tbl.push_back(mk(0, 7,  4'h0, 4'b1000, EM, 2'd3));
        // Reset in the middle of EMERG, then normal start-up timing.
        tbl.push_back(mk(1, 1,  4'h0, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 1,  4'h0, 4'h0, AR, 2'd3));
        tbl.push_back(mk(0, 1,  4'h0, 4'h0, GR, 2'd0));

        // Reset held three cycles with sec_tick toggling.
        for (int i = 0; i < 3; i++) begin
            sec_tick = i[0];
            step_cycle();
        end
        rst      = 1'b0;
        sec_tick = 1'b0;
        check_state("reset_state", AR, 2'd3);

        for (int v = 0; v < tbl.size(); v++) begin
            if (tbl[v].rst) begin
                rst         = 1'b1;
                car_waiting = tbl[v].car;
                emerg_req   = tbl[v].emerg;
                for (int i = 0; i < tbl[v].n; i++) begin
                    sec_tick = i[0];
                    step_cycle();
                end
                rst      = 1'b0;
                sec_tick = 1'b0;
            end else begin
                for (int i = 0; i < tbl[v].n; i++) do_tick(tbl[v].car, tbl[v].emerg);
            end
            check_state($sformatf("vec%0d", v), tbl[v].ph, tbl[v].lane);
        end

        // Emergency pulse between ticks must be ignored.
        emerg_req = 4'b0001;
        step_cycle();
        emerg_req = 4'b1000;
        step_cycle();
        emerg_req = 4'h0;
        do_tick(4'h0, 4'h0);
        check_state("pulse_between_ticks", GR, 2'd0);

        // Reset wins over a coincident sec_tick.
        sec_tick = 1'b1;
        rst      = 1'b1;
        step_cycle();
        rst      = 1'b0;
        sec_tick = 1'b0;
        check_state("reset_with_tick", AR, 2'd3);

        // State holds across many idle cycles, then resumes on ticks.
        repeat (12) step_cycle();
        check_state("idle_hold", AR, 2'd3);
        do_tick(4'h0, 4'h0);
        do_tick(4'h0, 4'h0);
        check_state("resume_green", GR, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Phase sequencer for the four-lane intersection. It sequences each lane through green, yellow and all-red clearance. Lanes with no waiting traffic are skipped, and emergency requests preempt the normal rotation. It drives the per-lane lamps directly and advances only on the one-second tick, so every phase length is an exact number of seconds.

## Interface
- GREEN_T, 30, normal green length in seconds (≥ MIN_GREEN, ≤ 31)
- YELLOW_T, 3, yellow length in seconds (≥ 1)
- CLEAR_T, 2, all-red clearance length in seconds (≥ 1)
- MIN_GREEN, 5, seconds of green served before preemption (≥ 1)
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse, once per second
- car_waiting  in  4  per-lane vehicle presence, bit i = lane i
- emerg_req  in  4  per-lane emergency request, level, held until served
- active_lane  out  2  lane currently owning (or last owning) green
- phase  out  2  0 = ALLRED, 1 = GREEN, 2 = YELLOW, 3 = EMERG
- lamp_g, lamp_y, lamp_r  out  4 each  per-lane lamp drives, one-hot per lane
- emerg_active  out  1  high while phase = EMERG

## Operation
- A 5-bit tick_cnt counts sec_tick pulses inside the current phase and clears to 0 on every phase change.
- All transitions and input sampling occur only on a clk edge with sec_tick = 1. With sec_tick low, all state holds.
- ALLRED: all lamp_r = 1. Exits when tick_cnt == CLEAR_T-1.
  - Next lane is chosen at that tick.
  - If emerg_req != 0: lowest-index requesting lane is selected and the phase goes to EMERG.
  - Else: first lane with car_waiting set, searching active_lane+1, +2, +3, +0 (mod 4), and the phase goes to GREEN.
  - If car_waiting == 0: active_lane+1 (mod 4), GREEN.
- GREEN: lamp_g[active_lane] = 1, other lanes red.
  - Goes to YELLOW when tick_cnt == GREEN_T-1.
  - Goes to YELLOW early if emerg_req has a bit set for a lane other than active_lane and tick_cnt ≥ MIN_GREEN-1.
  - Goes to EMERG, lane unchanged, if emerg_req[active_lane] = 1. This takes priority over both YELLOW exits.
- EMERG: lamp_g[active_lane] = 1. Held while emerg_req[active_lane] = 1. When it is 0 at a tick, goes to YELLOW. Requests on other lanes are ignored until then.
- YELLOW: lamp_y[active_lane] = 1, others red. Goes to ALLRED when tick_cnt == YELLOW_T-1.
- Lamp invariant: each lane has exactly one of g/y/r set. At most one lane is non-red.
- emerg_active = (phase == EMERG).
- Reset: phase = ALLRED, tick_cnt = 0, active_lane = 3. The first green therefore goes to lane 0 when no cars are waiting.
  - All lamp_r = 1, lamp_g = lamp_y = 0, emerg_active = 0.
- rst asserted mid-phase, in any phase, forces the reset state at the next clk edge regardless of sec_tick.
- Expected size is about 180 RTL lines.

## Timing
- All outputs are registered and change on the same clk edge that consumes the deciding sec_tick. Latency from the deciding tick to the lamp change is 0 cycles after that edge.
- Normal phase durations, counted in ticks: green = GREEN_T, yellow = YELLOW_T, clearance = CLEAR_T. A full uncontested lane slot is 35 ticks.
- Early preemption is exact: with an emergency on another lane asserted since green entry, green lasts exactly MIN_GREEN ticks.
- Emergency service latency from a request on an idle lane: remaining green (≥ 0), then YELLOW_T, then CLEAR_T ticks.
- emerg_req and car_waiting are sampled only at ticks. A pulse that falls between ticks is ignored.
- Simultaneous emergencies are served by lowest index at ALLRED exit. The remaining requests are served in later ALLRED decisions.

## Test plan
- Reset: hold rst 3 cycles with sec_tick toggling → lamp_r = 4'hF, phase = 0, active_lane = 3, emerg_active = 0. After 2 ticks: lane 0 green, phase = 1.
- Full rotation, car_waiting = 4'hF, ticks every 4 clks → each lane green 30 ticks, yellow 3, all-red 2. Order 0, 1, 2, 3, 0. Lamp one-hot checked every cycle.
- Skip, car_waiting = 4'b0100 during lane 0 green → after lane 0 yellow and clearance, lane 2 goes green. With car_waiting = 0: next lane is 1.
- Preemption: lane 0 green, emerg_req = 4'b1000 asserted at tick 10 → yellow at that tick, ALLRED after 3, then phase = 3 on lane 3 after 2. Drop request → yellow, then ALLRED. If asserted at tick 1, green ends exactly at tick 4 (MIN_GREEN = 5).
- Emergency on own lane plus simultaneous requests: lane 1 green, emerg_req = 4'b0110 → lane 1 goes to EMERG immediately. After the bit 1 request drops: yellow, clearance, then lane 2 EMERG. Repeat with 4'b1010 from ALLRED → lane 1 first.
- Reset mid-EMERG at tick 7 → next edge gives the reset state. Normal timing resumes after 2 ticks.
